// File: rtl/bus_reader_if.sv
// Signal bundle shared by the host/control logic, bus_reader and the LFSR data slaves.
// master = bus_reader's view; slave = the host plus slaves seen from the other side.
interface bus_reader_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic          req;
  logic [AW-1:0] req_addr;
  logic          busy;
  logic [AW-1:0] a;
  logic          q1_id;
  logic          d_en;
  logic          match;
  logic [DW-1:0] d;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rerr;

  modport master (
    input  req, req_addr, match, d,
    output busy, a, q1_id, d_en, rdata, rvalid, rerr
  );

  modport slave (
    output req, req_addr, match, d,
    input  busy, a, q1_id, d_en, rdata, rvalid, rerr
  );
endinterface

// File: rtl/bus_reader.sv
// Initiator of the LFSR data bus: address, confirm match, capture, drive, sample one word.
// Optional feature macro: BUS_READER_TIMEOUT_EN (ADDR waits up to TIMEOUT cycles for match).
module bus_reader #(
  parameter int AW      = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  bus_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_CAP  = 3'd2,
    S_DRV  = 3'd3,
    S_SMP  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("bus_reader: TIMEOUT must be at least 1");
  end

  state_t        state_r;
  logic          busy_r;
  logic [AW-1:0] a_r;
  logic          q1_id_r;
  logic          d_en_r;
  logic [DW-1:0] rdata_r;
  logic          rvalid_r;
  logic          rerr_r;

`ifdef BUS_READER_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_r;
`endif

  // Transaction sequencer; every bus-facing output is a flop updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      busy_r   <= 1'b0;
      a_r      <= {AW{1'b0}};
      q1_id_r  <= 1'b0;
      d_en_r   <= 1'b0;
      rdata_r  <= {DW{1'b0}};
      rvalid_r <= 1'b0;
      rerr_r   <= 1'b0;
`ifdef BUS_READER_TIMEOUT_EN
      cnt_r    <= {CW{1'b0}};
`endif
    end else begin
      // Strobes are single-cycle unless the state below re-asserts them.
      q1_id_r  <= 1'b0;
      rvalid_r <= 1'b0;
      rerr_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.req) begin
            a_r     <= bus.req_addr;
            busy_r  <= 1'b1;
            state_r <= S_ADDR;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ADDR: begin
          if (bus.match) begin
            q1_id_r <= 1'b1;
            state_r <= S_CAP;
`ifdef BUS_READER_TIMEOUT_EN
            cnt_r   <= {CW{1'b0}};
`endif
          end else begin
`ifdef BUS_READER_TIMEOUT_EN
            if (cnt_r == CNT_LAST) begin
              rerr_r  <= 1'b1;
              cnt_r   <= {CW{1'b0}};
              state_r <= S_ERR;
            end else begin
              cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
              state_r <= S_ADDR;
            end
`else
            rerr_r  <= 1'b1;
            state_r <= S_ERR;
`endif
          end
        end
        S_CAP: begin
          d_en_r  <= 1'b1;
          state_r <= S_DRV;
        end
        S_DRV: begin
          d_en_r  <= 1'b1;
          state_r <= S_SMP;
        end
        S_SMP: begin
          rdata_r  <= bus.d;
          d_en_r   <= 1'b0;
          rvalid_r <= 1'b1;
          state_r  <= S_DONE;
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        S_ERR: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          d_en_r  <= 1'b0;
          state_r <= S_IDLE;
`ifdef BUS_READER_TIMEOUT_EN
          cnt_r   <= {CW{1'b0}};
`endif
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.a      = a_r;
  assign bus.q1_id  = q1_id_r;
  assign bus.d_en   = d_en_r;
  assign bus.rdata  = rdata_r;
  assign bus.rvalid = rvalid_r;
  assign bus.rerr   = rerr_r;

endmodule

// File: tb/tb_bus_reader.sv
// Self-checking bench for bus_reader: table of directed reads plus reset and back-to-back sequences.
// Expected timing follows the build: BUS_READER_TIMEOUT_EN selects the timeout vector set.
module tb_bus_reader;
  localparam int AW      = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_reader_if #(.AW(AW), .DW(DW)) bus ();

  bus_reader #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Slave model: present slaves claim their address; data is only valid once d_en has settled a cycle.
  logic [DW-1:0] slave_word [16];
  logic [15:0]   present;
  logic          match_go;
  logic          d_en_q;
  always @(posedge clk) d_en_q <= bus.d_en;
  assign bus.match = match_go & present[bus.a];
  assign bus.d     = (bus.d_en && d_en_q) ? slave_word[bus.a] : 32'hBAD0_BAD0;

  wire [4:0] flags_s = {bus.busy, bus.q1_id, bus.d_en, bus.rvalid, bus.rerr};

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] rdata_model;

  typedef struct {
    logic [3:0]  addr;
    int          delay;
    logic        ok;
    int          fin;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Flag order: busy, q1_id, d_en, rvalid, rerr; k counts cycles after the accept edge.
  function automatic logic [4:0] exp_flags(input logic ok, input int fin, input int k);
    logic [4:0] f;
    f[4] = (k >= 1) && (k <= fin);
    f[3] = ok && (k == fin - 3);
    f[2] = ok && ((k == fin - 2) || (k == fin - 1));
    f[1] = ok && (k == fin);
    f[0] = !ok && (k == fin);
    return f;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [DW-1:0] exp_rd;
    bus.req      = 1'b1;
    bus.req_addr = v.addr;
    match_go     = 1'b0;
    tick();
    bus.req      = 1'b0;
    bus.req_addr = ~v.addr;
    for (int k = 1; k <= v.fin + 1; k++) begin
      if (k > 1) tick();
      exp_rd = (v.ok && k >= v.fin) ? v.exp_data : rdata_model;
      chk($sformatf("v%0d k%0d flags", idx, k), 64'(flags_s), 64'(exp_flags(v.ok, v.fin, k)));
      chk($sformatf("v%0d k%0d a", idx, k), 64'(bus.a), 64'(v.addr));
      chk($sformatf("v%0d k%0d rdata", idx, k), 64'(bus.rdata), 64'(exp_rd));
      match_go = (k >= v.delay + 1);
    end
    match_go    = 1'b0;
    rdata_model = v.exp_data;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) slave_word[i] = 32'h0000_0000;
    slave_word[5]  = 32'hDEAD_BEEF;
    slave_word[3]  = 32'h1234_5678;
    slave_word[9]  = 32'hCAFE_F00D;
    slave_word[15] = 32'h8000_0001;
    slave_word[0]  = 32'h0F0F_A5A5;
    present  = 16'h8229;
    match_go = 1'b0;
    bus.req      = 1'b0;
    bus.req_addr = 4'h0;

    vecs[0] = '{4'h5, 0, 1'b1, 5, 32'hDEAD_BEEF};
    vecs[1] = '{4'h3, 0, 1'b1, 5, 32'h1234_5678};
    vecs[2] = '{4'hA, 0, 1'b0, 2, 32'h1234_5678};
    vecs[3] = '{4'hF, 0, 1'b1, 5, 32'h8000_0001};
`ifdef BUS_READER_TIMEOUT_EN
    vecs[4] = '{4'h0, 2, 1'b1, 7, 32'h0F0F_A5A5};
    vecs[5] = '{4'h7, 0, 1'b0, 9, 32'h0F0F_A5A5};
`else
    vecs[4] = '{4'h0, 2, 1'b0, 2, 32'h8000_0001};
    vecs[5] = '{4'h7, 0, 1'b0, 2, 32'h8000_0001};
`endif

    // Power-on reset.
    rst = 1'b1;
    tick();
    tick();
    chk("reset flags", 64'(flags_s), 64'd0);
    chk("reset a", 64'(bus.a), 64'd0);
    chk("reset rdata", 64'(bus.rdata), 64'd0);
    rst = 1'b0;
    rdata_model = 32'h0000_0000;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Back-to-back: req held, req_addr switches to 9 during the first read.
    bus.req      = 1'b1;
    bus.req_addr = 4'h3;
    match_go     = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      int            j;
      logic [DW-1:0] exp_rd;
      if (k > 1) tick();
      if (k == 2) bus.req_addr = 4'h9;
      if (k == 12) bus.req = 1'b0;
      j = (k <= 6) ? k : k - 6;
      if (k >= 11)     exp_rd = 32'hCAFE_F00D;
      else if (k >= 5) exp_rd = 32'h1234_5678;
      else             exp_rd = rdata_model;
      chk($sformatf("b2b k%0d flags", k), 64'(flags_s), 64'(exp_flags(1'b1, 5, j)));
      chk($sformatf("b2b k%0d a", k), 64'(bus.a), (k <= 6) ? 64'h3 : 64'h9);
      chk($sformatf("b2b k%0d rdata", k), 64'(bus.rdata), 64'(exp_rd));
    end
    match_go    = 1'b0;
    rdata_model = 32'hCAFE_F00D;

    // Reset asserted for two cycles while the read of slave 5 is in SMP.
    bus.req      = 1'b1;
    bus.req_addr = 4'h5;
    match_go     = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    tick();
    tick();
    chk("pre-rst smp flags", 64'(flags_s), 64'(exp_flags(1'b1, 5, 4)));
    rst = 1'b1;
    tick();
    chk("rst smp flags", 64'(flags_s), 64'd0);
    chk("rst smp a", 64'(bus.a), 64'd0);
    chk("rst smp rdata", 64'(bus.rdata), 64'd0);
    tick();
    rst      = 1'b0;
    match_go = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post-rst k%0d flags", k), 64'(flags_s), 64'd0);
      chk($sformatf("post-rst k%0d rdata", k), 64'(bus.rdata), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_reader.md
# bus_reader

Initiator side of the LFSR data bus. On a host request it drives a 4-bit slave address, confirms a slave claims it, commands the slave to snapshot its LFSR value, enables the slave's tri-state drivers and registers the 32-bit word from the shared bus. It sits between the host/control logic and the bus of addressed data slaves. It is the only block that drives the address, capture and enable lines.

## Interface
Parameters:
- AW, 4, address width
- DW, 32, data bus width
- TIMEOUT, 8, maximum cycles to wait for an address match (used only with the timeout feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  host read request, level, sampled in IDLE
- req_addr  in  AW  slave address, latched on accept
- busy  out  1  transaction in progress (state != IDLE)
- a  out  AW  address to slaves
- q1_id  out  1  capture strobe: slave loads its LFSR value on the next edge
- d_en  out  1  slave tri-state output enable
- match  in  1  OR of all slaves' address-equal flags
- d  in  DW  shared data bus
- rdata  out  DW  last word read
- rvalid  out  1  one-cycle pulse: rdata updated
- rerr  out  1  one-cycle pulse: no slave matched

## Operation
- States: IDLE, ADDR, CAP, DRV, SMP, DONE, ERR.
- IDLE: when req=1, latch req_addr into a and go to ADDR. Otherwise stay.
- ADDR: a is stable. With match=1, go to CAP. With match=0, see Configuration.
- CAP: q1_id=1 for exactly one cycle, then go to DRV.
- DRV: d_en=1 so the bus settles, then go to SMP.
- SMP: d_en=1 and rdata<=d at the end of the cycle, then go to DONE.
- DONE: rvalid=1 and d_en=0, then go to IDLE.
- ERR: rerr=1, rdata is unchanged, then go to IDLE.
- a holds its value from accept until the next accept. Changes on req_addr are ignored while busy.
- req while busy is ignored, not queued. If req is held continuously, back-to-back reads occur, with at least one IDLE cycle between them.
- d_en is asserted only in DRV and SMP. It is never asserted at the same time as q1_id.
- Reset values: all outputs are 0, state is IDLE and the timeout counter is 0.
- rst mid-transaction: at the next edge all outputs are 0 and the state returns to IDLE. A partially read word is discarded and no rvalid or rerr is produced.

## Timing
- req accepted at edge T (state was IDLE). The rest of the sequence follows:
  - cycle T+1: ADDR
  - cycle T+2: CAP, q1_id=1
  - cycle T+3: DRV, d_en=1
  - cycle T+4: SMP, d sampled at end of cycle
  - cycle T+5: DONE, rvalid=1, rdata valid
- Latency from accept to rvalid is 5 cycles with an immediate match. Throughput is one read per 6 cycles.
- rdata holds its value until the next successful read.
- busy is 1 from T+1 through the DONE or ERR cycle inclusive.

## Configuration
- BUS_READER_TIMEOUT_EN defined:
  - ADDR waits for match, counting cycles in a counter of width clog2(TIMEOUT+1).
  - match within TIMEOUT ADDR cycles goes to CAP, and the counter clears.
  - After TIMEOUT ADDR cycles with no match, go to ERR.
  - Read latency grows by the number of extra wait cycles.
- BUS_READER_TIMEOUT_EN undefined:
  - No counter is built.
  - match=0 in the first ADDR cycle goes directly to ERR (rerr at T+2).

## Test plan
- Reset: hold rst 2 cycles mid-SMP. Required: all outputs 0 the next cycle, state IDLE, no rvalid; rdata is 0 after reset.
- Basic read: req_addr=4'h5, match=1, slave drives d=32'hDEADBEEF while d_en=1. Required:
  - q1_id pulses at T+2
  - d_en=1 at T+3..T+4
  - rvalid at T+5 with rdata=32'hDEADBEEF
- No match, macro undefined: match=0. Required: rerr=1 at T+2, q1_id and d_en never assert, rdata unchanged.
- Timeout, macro defined with TIMEOUT=8:
  - match rises on the 3rd ADDR cycle. Required: normal read, rvalid at T+7.
  - match never rises. Required: rerr after 8 ADDR cycles.
- Back-to-back reads: req held high with addresses 3 then 9, changing req_addr mid-transaction. Required:
  - a shows 3 for the whole first read
  - one IDLE cycle between reads
  - second rdata matches slave 9's word
